testsig_gen: RTL and testbench

Programmable, parametrised test-signal generator for the frequency-measurement datapath. It produces the square/pulse stimulus `sigin` with a runtime-loadable period and high time. New settings are accepted through a valid/ready handshake and applied glitch-free at period boundaries. It replaces fixed-divider test sources and feeds the measurement core and bench loopback.

---
 rtl/testsig_pkg.sv | 36 +++
 rtl/testsig_cfg_shadow.sv | 67 ++++++
 rtl/testsig_gen.sv | 187 ++++++++++++++++++
 tb/tb_testsig_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/testsig_pkg.sv
// Purpose: shared types, defaults and the config clamp for the test-signal generator.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Optional feature macro used by the design files: TESTSIG_BURST_EN.
package testsig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_PERIOD_C = 16000;
    localparam int DEF_HIGH_C   = 8000;

    // The clamp works on 32-bit values so a single function serves any
    // counter width up to 32 bits; callers cast back to their own width.
    function automatic logic [31:0] clamp_period(input logic [31:0] period);
        return (period < 32'd2) ? 32'd2 : period;
    endfunction

    // High time is clamped against the already-clamped period so that the
    // output always has at least one high and one low cycle per period.
    function automatic logic [31:0] clamp_high(input logic [31:0] period,
                                               input logic [31:0] high);
        logic [31:0] pc;
        logic [31:0] hc;
        pc = clamp_period(period);
        hc = (high == 32'd0) ? 32'd1 : high;
        if (hc >= pc) begin
            hc = pc - 32'd1;
        end
        return hc;
    endfunction

endpackage

// File: rtl/testsig_cfg_shadow.sv
// Purpose: clamps and holds one pending period/high configuration until applied.
// Latency: accepted config is visible on shd_*_o one cycle after the handshake.
// Backpressure: cfg_ready_o low while a config is pending; ready is a pure register output.
// Ports: sysclk/resetb clock and async active-low reset; cfg_valid_i/cfg_ready_o
//   handshake with cfg_period_i/cfg_high_i payload; apply_ok_i says the owner can
//   take the shadow this cycle; apply_o strobes when it does; shd_*_o hold the
//   clamped pending values.
module testsig_cfg_shadow
    import testsig_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             sysclk,
    input  logic             resetb,
    input  logic             cfg_valid_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic [CNT_W-1:0] cfg_high_i,
    input  logic             apply_ok_i,
    output logic             cfg_ready_o,
    output logic             apply_o,
    output logic [CNT_W-1:0] shd_period_o,
    output logic [CNT_W-1:0] shd_high_o
);

    logic             shd_full_q;
    logic             shd_full_d;
    logic [CNT_W-1:0] shd_period_q;
    logic [CNT_W-1:0] shd_period_d;
    logic [CNT_W-1:0] shd_high_q;
    logic [CNT_W-1:0] shd_high_d;
    logic             take;

    // A take and an apply are mutually exclusive: take needs an empty shadow,
    // apply needs a full one.
    assign take    = cfg_valid_i & ~shd_full_q;
    assign apply_o = shd_full_q & apply_ok_i;

    always_comb begin
        shd_full_d   = shd_full_q;
        shd_period_d = shd_period_q;
        shd_high_d   = shd_high_q;
        if (take) begin
            shd_full_d   = 1'b1;
            shd_period_d = CNT_W'(clamp_period(32'(cfg_period_i)));
            shd_high_d   = CNT_W'(clamp_high(32'(cfg_period_i), 32'(cfg_high_i)));
        end else if (apply_o) begin
            shd_full_d = 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge resetb) begin
        if (!resetb) begin
            shd_full_q   <= 1'b0;
            shd_period_q <= '0;
            shd_high_q   <= '0;
        end else begin
            shd_full_q   <= shd_full_d;
            shd_period_q <= shd_period_d;
            shd_high_q   <= shd_high_d;
        end
    end

    assign cfg_ready_o  = ~shd_full_q;
    assign shd_period_o = shd_period_q;
    assign shd_high_o   = shd_high_q;

endmodule

// File: rtl/testsig_gen.sv
// Purpose: programmable square/pulse generator with glitch-free config apply at period boundaries.
// Latency: sigin rises 1 cycle after enable is sampled high in IDLE.
// Backpressure: one config may be pending; cfg_ready stays low until it is applied.
// Ports: sysclk/resetb clock and async active-low reset; enable run request;
//   cfg_valid/cfg_ready/cfg_period/cfg_high config handshake; sigin generated
//   signal; period_tick pulse on each rising edge of sigin; active high in RUN.
//   With TESTSIG_BURST_EN defined: cfg_burst period count (0 = continuous) and
//   burst_done flag held in DONE until enable drops.
module testsig_gen
    import testsig_pkg::*;
#(
    parameter int CNT_W      = 24,
    parameter int DEF_PERIOD = DEF_PERIOD_C,
    parameter int DEF_HIGH   = DEF_HIGH_C
) (
    input  logic             sysclk,
    input  logic             resetb,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
`ifdef TESTSIG_BURST_EN
    input  logic [15:0]      cfg_burst,
    output logic             burst_done,
`endif
    output logic             sigin,
    output logic             period_tick,
    output logic             active
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] act_period_q;
    logic [CNT_W-1:0] act_period_d;
    logic [CNT_W-1:0] act_high_q;
    logic [CNT_W-1:0] act_high_d;
    logic             sigin_q;
    logic             sigin_d;
    logic             tick_q;
    logic             tick_d;
`ifdef TESTSIG_BURST_EN
    logic [15:0]      burst_left_q;
    logic [15:0]      burst_left_d;
    logic             done_q;
    logic             done_d;
`endif

    logic             at_wrap;
    logic [CNT_W-1:0] cnt_inc;
    logic             apply_ok;
    logic             apply;
    logic [CNT_W-1:0] shd_period;
    logic [CNT_W-1:0] shd_high;

    assign at_wrap = (cnt_q == act_period_q - ONE);
    assign cnt_inc = cnt_q + ONE;

    // IDLE takes the shadow at once; RUN only on the last cycle of a period,
    // so the next period starts cleanly with the new values.
    assign apply_ok = (state_q == ST_IDLE) | ((state_q == ST_RUN) & at_wrap);

    testsig_cfg_shadow #(
        .CNT_W (CNT_W)
    ) u_shadow (
        .sysclk       (sysclk),
        .resetb       (resetb),
        .cfg_valid_i  (cfg_valid),
        .cfg_period_i (cfg_period),
        .cfg_high_i   (cfg_high),
        .apply_ok_i   (apply_ok),
        .cfg_ready_o  (cfg_ready),
        .apply_o      (apply),
        .shd_period_o (shd_period),
        .shd_high_o   (shd_high)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sigin_d      = sigin_q;
        tick_d       = 1'b0;
        act_period_d = apply ? shd_period : act_period_q;
        act_high_d   = apply ? shd_high   : act_high_q;
`ifdef TESTSIG_BURST_EN
        burst_left_d = burst_left_q;
        done_d       = done_q;
`endif
        case (state_q)
            ST_IDLE: begin
                sigin_d = 1'b0;
                if (enable) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    sigin_d = 1'b1;
                    tick_d  = 1'b1;
`ifdef TESTSIG_BURST_EN
                    burst_left_d = cfg_burst;
`endif
                end
            end
            ST_RUN: begin
                if (at_wrap) begin
                    cnt_d = '0;
                    if (!enable) begin
                        // Run request withdrawn: finish here, no new period.
                        state_d = ST_IDLE;
                        sigin_d = 1'b0;
`ifdef TESTSIG_BURST_EN
                    end else if (burst_left_q == 16'd1) begin
                        state_d = ST_DONE;
                        sigin_d = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
`ifdef TESTSIG_BURST_EN
                        // Zero means continuous, so it is never decremented.
                        if (burst_left_q != 16'd0) begin
                            burst_left_d = burst_left_q - 16'd1;
                        end
`endif
                        sigin_d = 1'b1;
                        tick_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    // High is clamped below the period, so this never
                    // coincides with the wrap.
                    if (cnt_inc == act_high_q) begin
                        sigin_d = 1'b0;
                    end
                end
            end
`ifdef TESTSIG_BURST_EN
            ST_DONE: begin
                sigin_d = 1'b0;
                if (!enable) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                sigin_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            act_period_q <= CNT_W'(DEF_PERIOD);
            act_high_q   <= CNT_W'(DEF_HIGH);
            sigin_q      <= 1'b0;
            tick_q       <= 1'b0;
`ifdef TESTSIG_BURST_EN
            burst_left_q <= '0;
            done_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            act_period_q <= act_period_d;
            act_high_q   <= act_high_d;
            sigin_q      <= sigin_d;
            tick_q       <= tick_d;
`ifdef TESTSIG_BURST_EN
            burst_left_q <= burst_left_d;
            done_q       <= done_d;
`endif
        end
    end

    assign sigin       = sigin_q;
    assign period_tick = tick_q;
    assign active      = (state_q == ST_RUN);
`ifdef TESTSIG_BURST_EN
    assign burst_done  = done_q;
`endif

endmodule

// File: tb/tb_testsig_gen.sv
// Purpose: directed self-checking bench for testsig_gen (defaults, reconfig, clamps,
//   enable drop, async reset; burst mode when TESTSIG_BURST_EN is defined).
// Latency/backpressure: inputs driven and outputs sampled on the falling edge.
module tb_testsig_gen;

    localparam int CNT_W = 24;

    logic             sysclk;
    logic             resetb;
    logic             enable;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_high;
    logic             sigin;
    logic             period_tick;
    logic             active;
`ifdef TESTSIG_BURST_EN
    logic [15:0]      cfg_burst;
    logic             burst_done;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    testsig_gen #(
        .CNT_W (CNT_W)
    ) dut (
        .sysclk      (sysclk),
        .resetb      (resetb),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
`ifdef TESTSIG_BURST_EN
        .cfg_burst   (cfg_burst),
        .burst_done  (burst_done),
`endif
        .sigin       (sigin),
        .period_tick (period_tick),
        .active      (active)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge sysclk);
    endtask

    // Counts high cycles and ticks over n cycles, starting at the current
    // falling edge; ends n falling edges later.
    task automatic measure(input int n, output int hi, output int tk);
        hi = 0;
        tk = 0;
        for (int i = 0; i < n; i++) begin
            if (sigin) hi++;
            if (period_tick) tk++;
            step();
        end
    endtask

    task automatic offer(input int p, input int h);
        cfg_valid  = 1'b1;
        cfg_period = CNT_W'(p);
        cfg_high   = CNT_W'(h);
    endtask

    int hi;
    int tk;

    initial begin
        resetb     = 1'b0;
        enable     = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_high   = '0;
`ifdef TESTSIG_BURST_EN
        cfg_burst  = '0;
`endif
        step();
        step();
        chk("rst_sigin", 32'(sigin), 32'd0);
        chk("rst_tick", 32'(period_tick), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        resetb = 1'b1;
        step();

        // Defaults: 8000 high / 8000 low.
        enable = 1'b1;
        step();
        chk("start_sigin", 32'(sigin), 32'd1);
        chk("start_tick", 32'(period_tick), 32'd1);
        chk("start_active", 32'(active), 32'd1);
        measure(16000, hi, tk);
        chk("def_high", 32'(hi), 32'd8000);
        chk("def_ticks", 32'(tk), 32'd1);
        chk("def_tick2", 32'(period_tick), 32'd1);

        // 10/3 loaded mid-period: the 16000-cycle period completes first.
        offer(10, 3);
        step();
        cfg_valid = 1'b0;
        chk("p10_ready_low", 32'(cfg_ready), 32'd0);
        measure(15998, hi, tk);
        chk("p10_old_high", 32'(hi), 32'd7999);
        chk("p10_old_ticks", 32'(tk), 32'd0);
        chk("p10_ready_end", 32'(cfg_ready), 32'd0);
        step();
        chk("p10_ready_back", 32'(cfg_ready), 32'd1);
        chk("p10_tick", 32'(period_tick), 32'd1);
        measure(20, hi, tk);
        chk("p10_high", 32'(hi), 32'd6);
        chk("p10_ticks", 32'(tk), 32'd2);

        // 1/0 clamps to 2/1.
        offer(1, 0);
        step();
        cfg_valid = 1'b0;
        measure(9, hi, tk);
        chk("p2_prev_high", 32'(hi), 32'd2);
        measure(8, hi, tk);
        chk("p2_high", 32'(hi), 32'd4);
        chk("p2_ticks", 32'(tk), 32'd4);

        // 5/9 clamps to high 4.
        offer(5, 9);
        step();
        cfg_valid = 1'b0;
        measure(1, hi, tk);
        chk("p5_prev_high", 32'(hi), 32'd0);
        measure(10, hi, tk);
        chk("p5_high", 32'(hi), 32'd8);
        chk("p5_ticks", 32'(tk), 32'd2);

        // Back to 10/3, then drop enable at cnt=2.
        offer(10, 3);
        step();
        cfg_valid = 1'b0;
        measure(4, hi, tk);
        chk("p5_tail_high", 32'(hi), 32'd3);
        chk("dis_tick0", 32'(period_tick), 32'd1);
        step();
        step();
        enable = 1'b0;
        measure(8, hi, tk);
        chk("dis_high", 32'(hi), 32'd1);
        chk("dis_ticks", 32'(tk), 32'd0);
        chk("dis_sigin", 32'(sigin), 32'd0);
        chk("dis_active", 32'(active), 32'd0);
        measure(5, hi, tk);
        chk("idle_high", 32'(hi), 32'd0);
        chk("idle_ticks", 32'(tk), 32'd0);

        // Reset mid-high with a pending shadow.
        enable = 1'b1;
        step();
        chk("rr_start", 32'(sigin), 32'd1);
        offer(20, 5);
        step();
        cfg_valid = 1'b0;
        chk("rr_pending", 32'(cfg_ready), 32'd0);
        chk("rr_high", 32'(sigin), 32'd1);
        resetb = 1'b0;
        #1;
        chk("rr_sigin", 32'(sigin), 32'd0);
        chk("rr_ready", 32'(cfg_ready), 32'd1);
        chk("rr_active", 32'(active), 32'd0);
        step();
        resetb = 1'b1;
        step();
        chk("rr_restart", 32'(period_tick), 32'd1);
        measure(16000, hi, tk);
        chk("rr_def_high", 32'(hi), 32'd8000);
        chk("rr_def_ticks", 32'(tk), 32'd1);

`ifdef TESTSIG_BURST_EN
        // Burst of 3 periods of 4/2.
        enable = 1'b0;
        resetb = 1'b0;
        step();
        resetb = 1'b1;
        offer(4, 2);
        step();
        cfg_valid = 1'b0;
        step();
        cfg_burst = 16'd3;
        enable    = 1'b1;
        step();
        measure(12, hi, tk);
        chk("bu_ticks", 32'(tk), 32'd3);
        chk("bu_high", 32'(hi), 32'd6);
        chk("bu_done", 32'(burst_done), 32'd1);
        chk("bu_sigin", 32'(sigin), 32'd0);
        chk("bu_active", 32'(active), 32'd0);
        measure(6, hi, tk);
        chk("bu_hold_ticks", 32'(tk), 32'd0);
        chk("bu_hold_done", 32'(burst_done), 32'd1);
        enable = 1'b0;
        step();
        chk("bu_clear", 32'(burst_done), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
